// File: rtl/ss_pkg.sv
// Shared types and parameter legality checks for the stochastic pulse de-stretcher.
package ss_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ss_state_e;

  // Legal iff run counter can hold LIMIT+1 and COUNT can hold a full window of pulses.
  function automatic bit params_ok(input int unsigned n, input int unsigned limit,
                                   input int unsigned window, input int unsigned w);
    bit ok;
    ok = (n >= 1) && (n <= 32) && (w >= 1) && (w <= 32) && (window >= 2);
    if (ok) begin
      ok = ((64'd1 << n) > (64'(limit) + 64'd1)) && ((64'd1 << w) > 64'(window));
    end
    return ok;
  endfunction

endpackage

// File: rtl/ss_demagn_if.sv
// Stream-side bundle of the de-stretcher: stretched input plus regenerated pulse and rate outputs.
interface ss_demagn_if #(
  parameter int unsigned W = 16
) ();

  logic         IN;
  logic         OUT;
  logic         FMT_ERR;
  logic [W-1:0] COUNT;
  logic         COUNT_VALID;

  modport master (
    output IN,
    input  OUT,
    input  FMT_ERR,
    input  COUNT,
    input  COUNT_VALID
  );

  modport slave (
    input  IN,
    output OUT,
    output FMT_ERR,
    output COUNT,
    output COUNT_VALID
  );

endinterface

// File: rtl/ss_window_cnt.sv
// Fixed-window pulse rate meter: publishes the pulse count of each completed WINDOW-cycle window.
module ss_window_cnt #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned W      = 16
) (
  input  logic         CLK,
  input  logic         INIT_N,
  input  logic         emit,
  output logic [W-1:0] count,
  output logic         count_valid
);

  localparam int unsigned WCW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(WINDOW - 1);

  logic [WCW-1:0] wcnt_q;
  logic [W-1:0]   pcnt_q;
  logic [W-1:0]   pcnt_inc_c;
  logic           last_c;
  logic [W-1:0]   count_q;
  logic           count_valid_q;

  // Saturating accumulate; a pulse on the closing cycle is folded into that window.
  always_comb begin
    pcnt_inc_c = pcnt_q;
    if (emit && (pcnt_q != {W{1'b1}})) begin
      pcnt_inc_c = pcnt_q + W'(1);
    end
    last_c = (wcnt_q == WLAST);
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      wcnt_q        <= '0;
      pcnt_q        <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
    end else if (last_c) begin
      wcnt_q        <= '0;
      pcnt_q        <= '0;
      count_q       <= pcnt_inc_c;
      count_valid_q <= 1'b1;
    end else begin
      wcnt_q        <= wcnt_q + WCW'(1);
      pcnt_q        <= pcnt_inc_c;
      count_valid_q <= 1'b0;
    end
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;

endmodule

// File: rtl/ss_demagn.sv
// Stochastic pulse de-stretcher: turns LIMIT+1-cycle high runs back into single-cycle pulses,
// flags short runs, and meters the regenerated pulse rate per window.
module ss_demagn
  import ss_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned LIMIT  = 5,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned W      = 16
) (
  input  logic         CLK,
  input  logic         INIT_N,
  ss_demagn_if.slave   bus
);

  if (!params_ok(N, LIMIT, WINDOW, W)) begin : g_bad_params
    $fatal(1, "ss_demagn: illegal parameters N=%0d LIMIT=%0d WINDOW=%0d W=%0d",
           N, LIMIT, WINDOW, W);
  end

  localparam logic [N-1:0] RCNT_WRAP = N'(LIMIT);
  localparam logic [N-1:0] RLEN_FULL = N'(LIMIT + 1);

  ss_state_e    state_q, state_d;
  logic [N-1:0] rcnt_q, rcnt_d;
  logic [N-1:0] rlen_q, rlen_d;
  logic         emit_c;
  logic         fmt_err_d;
  logic         out_q;
  logic         fmt_err_q;

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      rlen_q    <= '0;
      out_q     <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      rlen_q    <= rlen_d;
      out_q     <= emit_c;
      fmt_err_q <= fmt_err_d;
    end
  end

  // Pulses land on run offsets 0, LIMIT+1, 2(LIMIT+1), ...; RLEN only needs to reach LIMIT+1.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rlen_d    = rlen_q;
    emit_c    = 1'b0;
    fmt_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.IN) begin
          emit_c  = 1'b1;
          state_d = RUN;
          rcnt_d  = '0;
          rlen_d  = N'(1);
        end
      end
      RUN: begin
        if (bus.IN) begin
          if (rcnt_q == RCNT_WRAP) begin
            emit_c = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + N'(1);
          end
          if (rlen_q < RLEN_FULL) begin
            rlen_d = rlen_q + N'(1);
          end
        end else begin
          state_d   = IDLE;
          fmt_err_d = (rlen_q < RLEN_FULL);
          rcnt_d    = '0;
          rlen_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
        rlen_d  = '0;
      end
    endcase
  end

  ss_window_cnt #(
    .WINDOW (WINDOW),
    .W      (W)
  ) u_window_cnt (
    .CLK         (CLK),
    .INIT_N      (INIT_N),
    .emit        (emit_c),
    .count       (bus.COUNT),
    .count_valid (bus.COUNT_VALID)
  );

  assign bus.OUT     = out_q;
  assign bus.FMT_ERR = fmt_err_q;

endmodule

// File: tb/tb_ss_demagn.sv
// Scoreboard bench for ss_demagn with LIMIT=5, WINDOW=16, W=8; expected events are hand-placed
// by edge number and matched by an independent monitor.
module tb_ss_demagn;

  typedef struct {
    int cyc;
    int val;
  } cnt_exp_t;

  logic clk;
  logic init_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   base;

  int       out_q[$];
  int       fmt_q[$];
  cnt_exp_t cnt_q[$];
  int       mon_e;
  cnt_exp_t mon_c;

  ss_demagn_if #(.W(8)) bus ();

  ss_demagn #(
    .N      (16),
    .LIMIT  (5),
    .WINDOW (16),
    .W      (8)
  ) dut (
    .CLK    (clk),
    .INIT_N (init_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one IN sample; p/f mark that this sample should yield an OUT pulse / FMT_ERR strobe.
  task automatic drv(input bit v, input bit p, input bit f);
    bus.IN = v;
    if (p) out_q.push_back(cyc + 1);
    if (f) fmt_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit in_v);
    init_n = 1'b0;
    bus.IN = in_v;
    repeat (2) @(posedge clk);
    #1;
    init_n = 1'b1;
  endtask

  // Monitor: every asserted output event consumes one scoreboard entry.
  always @(negedge clk) begin
    if (init_n) begin
      if (bus.OUT) begin
        total++;
        if (out_q.size() == 0) begin
          bad++;
          $display("FAIL out_pulse: unexpected pulse at cycle %0d", cyc);
        end else begin
          mon_e = out_q.pop_front();
          if (mon_e != cyc) begin
            bad++;
            $display("FAIL out_pulse: got pulse at cycle %0d expected cycle %0d", cyc, mon_e);
          end
        end
      end
      if (bus.FMT_ERR) begin
        total++;
        if (fmt_q.size() == 0) begin
          bad++;
          $display("FAIL fmt_err: unexpected strobe at cycle %0d", cyc);
        end else begin
          mon_e = fmt_q.pop_front();
          if (mon_e != cyc) begin
            bad++;
            $display("FAIL fmt_err: got strobe at cycle %0d expected cycle %0d", cyc, mon_e);
          end
        end
      end
      if (bus.COUNT_VALID) begin
        total++;
        if (cnt_q.size() == 0) begin
          bad++;
          $display("FAIL count: unexpected COUNT_VALID at cycle %0d (COUNT=%0d)", cyc, bus.COUNT);
        end else begin
          mon_c = cnt_q.pop_front();
          if ((mon_c.cyc != cyc) || (int'(bus.COUNT) != mon_c.val)) begin
            bad++;
            $display("FAIL count: got COUNT=%0d at cycle %0d expected COUNT=%0d at cycle %0d",
                     bus.COUNT, cyc, mon_c.val, mon_c.cyc);
          end
        end
      end
    end
  end

  initial begin
    init_n = 1'b0;
    bus.IN = 1'b0;

    // Reset state
    do_reset(1'b0);
    chk("rst_out", int'(bus.OUT), 0);
    chk("rst_fmt_err", int'(bus.FMT_ERR), 0);
    chk("rst_count", int'(bus.COUNT), 0);
    chk("rst_count_valid", int'(bus.COUNT_VALID), 0);

    // Isolated run of exactly LIMIT+1
    for (int i = 0; i < 6; i++) drv(1'b1, i == 0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);

    // Merged run of 14: pulses at offsets 0, 6, 12
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) drv(1'b1, (i == 0) || (i == 6) || (i == 12), 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);

    // Short run of 3: one pulse, FMT_ERR on the first low sample
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) drv(1'b1, i == 0, 1'b0);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0);

    // Minimal gap between two full runs: pulses 7 cycles apart
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) drv(1'b1, i == 0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drv(1'b1, i == 0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);

    // Rate window: IN high from release, windows close at edges 16 and 32 with 3 pulses each
    do_reset(1'b1);
    base = cyc;
    cnt_q.push_back('{base + 16, 3});
    cnt_q.push_back('{base + 32, 3});
    for (int i = 0; i < 32; i++)
      drv(1'b1, (i == 0) || (i == 6) || (i == 12) || (i == 18) || (i == 24) || (i == 30), 1'b0);
    drv(1'b1, 1'b0, 1'b0);
    chk("count_held", int'(bus.COUNT), 3);
    chk("count_valid_one_cycle", int'(bus.COUNT_VALID), 0);
    @(negedge clk);
    #1;
    init_n = 1'b0;
    #1;
    chk("async_rst_count", int'(bus.COUNT), 0);
    chk("async_rst_count_valid", int'(bus.COUNT_VALID), 0);
    chk("async_rst_out", int'(bus.OUT), 0);

    // Pulse on the last window cycle counts in the closing window; empty window reports 0
    do_reset(1'b0);
    base = cyc;
    cnt_q.push_back('{base + 16, 3});
    cnt_q.push_back('{base + 32, 0});
    for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) drv(1'b1, (i == 0) || (i == 6) || (i == 12), 1'b0);
    for (int i = 0; i < 17; i++) drv(1'b0, 1'b0, 1'b0);

    // Reset mid-run at offset 4, release with IN high
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) drv(1'b1, i == 0, 1'b0);
    init_n = 1'b0;
    #1;
    chk("midrun_rst_out", int'(bus.OUT), 0);
    chk("midrun_rst_fmt_err", int'(bus.FMT_ERR), 0);
    chk("midrun_rst_count", int'(bus.COUNT), 0);
    chk("midrun_rst_count_valid", int'(bus.COUNT_VALID), 0);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) drv(1'b1, i == 0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);

    // Every expected event must have been observed
    chk("out_pending", out_q.size(), 0);
    chk("fmt_pending", fmt_q.size(), 0);
    chk("count_pending", cnt_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
